// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode encoding, queued command
// layout, sequencer FSM states and datapath widths.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_CLR0 = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_NOTA = 3'b101,
        OP_NOTB = 3'b110,
        OP_CLR7 = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_e           op;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    function automatic alu_cmd_t make_cmd(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic [OP_W-1:0]   op);
        alu_cmd_t c;
        c.a  = a;
        c.b  = b;
        c.op = alu_op_e'(op);
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from a registered count so a word
// written into an empty FIFO is not visible at the head until the next cycle.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Flow-controlled front end for the 4-bit combinational ALU: queues commands,
// drives registered operands, captures the result. Optional ALU_SEQ_STICKY_OVF_EN.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_overflow,
    output logic              ovf_sticky
);

    seq_state_e        state_q,     state_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    alu_op_e           alu_op_q,    alu_op_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;
    logic              res_ovf_q,   res_ovf_d;
    logic              res_valid_q, res_valid_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    alu_cmd_t          push_cmd;
    logic [CMD_W-1:0]  fifo_head;
    alu_cmd_t          head_cmd;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign push_cmd  = make_cmd(cmd_a, cmd_b, cmd_op);
    assign head_cmd  = alu_cmd_t'(fifo_head);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_a_d  = head_cmd.a;
                    alu_b_d  = head_cmd.b;
                    alu_op_d = head_cmd.op;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d  = alu_result;
                res_ovf_d   = alu_overflow;
                res_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Result stays frozen until the consumer takes it; the next
                // command is popped on the same edge to sustain 2 cycles/result.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        alu_a_d  = head_cmd.a;
                        alu_b_d  = head_cmd.b;
                        alu_op_d = head_cmd.op;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_CLR0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_overflow = res_ovf_q;

`ifdef ALU_SEQ_STICKY_OVF_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (res_valid_q && res_ready && res_ovf_q) begin
            sticky_q <= 1'b1;
        end
    end

    assign ovf_sticky = sticky_q;
`else
    assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: an environment ALU answers the DUT,
// an arithmetic reference model predicts each result in acceptance order.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
`ifdef ALU_SEQ_STICKY_OVF_EN
    localparam logic STICKY_EN = 1'b1;
`else
    localparam logic STICKY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       res_overflow;
    logic       ovf_sticky;

    int checks = 0;
    int failures = 0;
    int n_results = 0;
    int rdy_mode = 1;          // 0 = hold low, 1 = hold high, 2 = random
    logic [4:0] exp_q [$];     // {overflow, result} in acceptance order

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .ovf_sticky   (ovf_sticky)
    );

    // Environment: the combinational ALU the sequencer fronts.
    always_comb begin
        logic [3:0] t;
        t = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b001: begin
                t = alu_a + alu_b;
                alu_result   = t;
                alu_overflow = (alu_a[3] == alu_b[3]) && (t[3] != alu_a[3]);
            end
            3'b010: begin
                t = alu_a - alu_b;
                alu_result   = t;
                alu_overflow = (alu_a[3] != alu_b[3]) && (t[3] != alu_a[3]);
            end
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = ~alu_b;
            default: alu_result = '0;
        endcase
    end

    // Reference: signed integer arithmetic with range check for overflow.
    function automatic logic [4:0] ref_result(input logic [3:0] a, input logic [3:0] b,
                                              input logic [2:0] op);
        int sa, sb, r;
        logic ovf;
        logic [3:0] v;
        sa  = a[3] ? int'(a) - 16 : int'(a);
        sb  = b[3] ? int'(b) - 16 : int'(b);
        ovf = 1'b0;
        v   = '0;
        r   = 0;
        case (op)
            3'd1: begin r = sa + sb; ovf = (r > 7) || (r < -8); v = 4'(r & 15); end
            3'd2: begin r = sa - sb; ovf = (r > 7) || (r < -8); v = 4'(r & 15); end
            3'd3: v = a & b;
            3'd4: v = a | b;
            3'd5: v = 4'(15 - int'(a));
            3'd6: v = 4'(15 - int'(b));
            default: v = '0;
        endcase
        return {ovf, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares each consumed result and checks held results stay stable.
    logic       hold_prev = 1'b0;
    logic [4:0] hold_val = '0;
    always @(negedge clk) begin
        logic [4:0] e;
        if (rst) begin
            hold_prev = 1'b0;
        end else if (res_valid) begin
            if (hold_prev) check("res_stable", {27'd0, res_overflow, res_data}, {27'd0, hold_val});
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none", {res_overflow, res_data});
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", {28'd0, res_data}, {28'd0, e[3:0]});
                    check("res_ovf", {31'd0, res_overflow}, {31'd0, e[4]});
                    $display("result %0d: data=%b ovf=%b exp=%b/%b", n_results, res_data,
                             res_overflow, e[3:0], e[4]);
                    n_results++;
                end
                hold_prev = 1'b0;
            end else begin
                hold_prev = 1'b1;
                hold_val  = {res_overflow, res_data};
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input int max_wait, output bit acc);
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        acc = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                exp_q.push_back(ref_result(a, b, op));
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (exp_q.size() == 0 && !res_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        int n_before;
        logic [3:0] held;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {28'd0, res_data}, 32'd0);
        check("rst_res_ovf", {31'd0, res_overflow}, 32'd0);
        check("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        check("rst_alu_ops", {21'd0, alu_a, alu_b, alu_op}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single add with latency measurement.
        send(4'b0111, 4'b0001, 3'b001, 10, acc);
        check("t1_accept", {31'd0, acc}, 32'd1);
        @(negedge clk);
        check("lat_edge_t", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("lat_edge_t1", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("lat_edge_t2", {31'd0, res_valid}, 32'd1);
        @(posedge clk);
        #1;
        drain();
        check("sticky_after_add", {31'd0, ovf_sticky}, {31'd0, STICKY_EN});

        // Subtractions, overflowing and not.
        send(4'b1000, 4'b0001, 3'b010, 10, acc);
        send(4'b0011, 4'b0001, 3'b010, 10, acc);
        drain();
        check("sticky_after_sub", {31'd0, ovf_sticky}, {31'd0, STICKY_EN});

        // Backpressure: DEPTH+1 accepted then cmd_ready falls.
        rdy_mode = 0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'(i % 8), 4, acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", n_acc, DEPTH + 1);
        check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        held = res_data;
        repeat (5) @(posedge clk);
        #1;
        check("bp_valid_held", {31'd0, res_valid}, 32'd1);
        check("bp_data_held", {28'd0, res_data}, {28'd0, held});
        n_before = n_results;
        rdy_mode = 1;
        drain();
        check("bp_results", n_results - n_before, DEPTH + 1);

        // Wrap-around with random res_ready.
        rdy_mode = 2;
        n_acc = 0;
        n_before = n_results;
        for (int i = 0; i < 12; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(3, 6)), 60, acc);
            if (acc) n_acc++;
        end
        check("wrap_accepted", n_acc, 12);
        drain();
        check("wrap_results", n_results - n_before, 12);

        // Reset with one result in RESP and three queued.
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            send(4'b0111, 4'($urandom_range(1, 15)), 3'b001, 5, acc);
        end
        for (int i = 0; i < 20 && !res_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_alu_op", {29'd0, alu_op}, 32'd0);
        check("mid_rst_sticky", {31'd0, ovf_sticky}, 32'd0);
        rst = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale", {31'd0, res_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Sticky after reset, then random mixed traffic.
        send(4'b0101, 4'b0100, 3'b001, 10, acc);
        drain();
        check("sticky_set", {31'd0, ovf_sticky}, {31'd0, STICKY_EN});
        send(4'b0011, 4'b0101, 3'b011, 10, acc);
        drain();
        check("sticky_hold", {31'd0, ovf_sticky}, {31'd0, STICKY_EN});

        rdy_mode = 2;
        n_before = n_results;
        for (int i = 0; i < 16; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 60, acc);
        end
        rdy_mode = 1;
        drain();
        check("mixed_results", n_results - n_before, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-buffering front end for the 4-bit combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and queues them in a small FIFO. It drives registered A/B/Op into the ALU, captures the ALU result and overflow one cycle later, and presents them downstream over a second valid/ready handshake. Its job is to turn the bare combinational ALU into a flow-controlled pipeline stage.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_op  in  3  opcode, ALU encoding (000 clr, 001 add, 010 sub, 011 and, 100 or, 101 not A, 110 not B, 111 clr)
- alu_a  out  4  registered operand A to ALU
- alu_b  out  4  registered operand B to ALU
- alu_op  out  3  registered opcode to ALU
- alu_result  in  4  ALU combinational result
- alu_overflow  in  1  ALU signed-overflow flag
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts
- res_data  out  4  captured result
- res_overflow  out  1  captured overflow
- ovf_sticky  out  1  sticky overflow status (see Configuration)

## Operation
- Push: cmd_valid && cmd_ready at an edge writes {a,b,op} at the write pointer. Pointers wrap modulo DEPTH. The count is $clog2(DEPTH+1) bits.
- cmd_ready depends only on full. There is no pass-through when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle are allowed when not full and not empty. The count is unchanged.
- An entry is never popped in the cycle it is pushed into an empty FIFO. Pop eligibility uses the registered count.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if the FIFO is non-empty, pop, load alu_a/alu_b/alu_op from the head entry, go to EXEC. Otherwise stay.
  - EXEC: capture alu_result→res_data and alu_overflow→res_overflow, set res_valid, go to RESP.
  - RESP: hold res_valid and res_data/res_overflow stable until res_valid && res_ready.
    - On that handshake, if the FIFO is non-empty: pop, load the operand registers, go to EXEC, and drop res_valid.
    - Otherwise: drop res_valid and go to IDLE.
- The operand registers hold their last values outside pop cycles.
- The block forwards opcodes unchanged and does not interpret them. Opcodes 000 and 111 flow through as normal commands, giving a result of 0000 and overflow 0.

## Timing
- Reset values:
  - cmd_ready=1, res_valid=0, res_data=0000, res_overflow=0, ovf_sticky=0
  - alu_a=0000, alu_b=0000, alu_op=000
  - FIFO empty, state IDLE
- Reset mid-operation discards all queued and in-flight commands. Any pending result is lost.
- Latency from an accepting edge t with an empty FIFO and the FSM in IDLE:
  - pop at edge t+1
  - res_valid high after edge t+2
- Throughput: one result per 2 cycles with res_ready held high.
- With res_ready held low, DEPTH+1 commands are accepted before cmd_ready falls: one is held in RESP, DEPTH are queued.

## Configuration
- Macro: ALU_SEQ_STICKY_OVF_EN.
- Defined: ovf_sticky is set on any result handshake (res_valid && res_ready) with res_overflow=1. It clears only on rst.
- Not defined: ovf_sticky is tied to 0 and no sticky register is built. The port stays present.

## Structure
- Shared package alu_pkg holds:
  - opcode enum (OP_CLR0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOTA, OP_NOTB, OP_CLR7)
  - command struct {a,b,op}
  - FSM state enum
  - width constants (DATA_W=4, OP_W=3)
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with push/pop/full/empty/head outputs.
- The sequencer instantiates alu_cmd_fifo and contains the FSM and the result registers.

## Test plan
- Single add, res_ready=1: a=0111, b=0001, op=001 → res_data=1000, res_overflow=1, res_valid exactly 2 edges after acceptance.
- Sub: a=1000, b=0001, op=010 → res_data=0111, res_overflow=1. Then a=0011, b=0001, op=010 → 0010, overflow 0.
- Backpressure, res_ready=0, 6 commands offered → exactly 5 accepted, then cmd_ready=0. res_data stays stable. Release res_ready → all 5 results in order.
- Wrap-around: stream 12 commands (AND/OR/NOT patterns) through DEPTH=4 with random res_ready → results match an in-order reference model, nothing dropped or duplicated.
- Reset mid-operation: rst asserted with 3 queued and one in RESP → next cycle res_valid=0, cmd_ready=1, alu_op=000. No stale result after reset.
- Sticky flag, macro defined: one overflowing add is accepted → ovf_sticky=1 and stays 1 through non-overflowing ops until rst. With the macro undefined it stays 0.
